// File: rtl/jk_bank_pkg.sv
// rtl/jk_bank_pkg.sv - shared mode enum and JK input codes for the jk_bank slice
package jk_bank_pkg;

    typedef enum logic [1:0] {
        JK   = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10,
        LOAD = 2'b11
    } mode_e;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] CLR  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] TGL  = 2'b11;

endpackage

// File: rtl/jk_bank_if.sv
// rtl/jk_bank_if.sv - control/data bundle between a jk_bank and its user
import jk_bank_pkg::*;

interface jk_bank_if #(
    parameter int WIDTH = 8
);
    logic             en;
    mode_e            mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;

    modport master (output en, mode, j, k, d, input q, qbar, tc);
    modport slave  (input en, mode, j, k, d, output q, qbar, tc);
endinterface

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with synchronous reset to a per-cell value
import jk_bank_pkg::*;

module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= rst_val;
        end else begin
            case ({j, k})
                HOLD:    q <= q;
                CLR:     q <= 1'b0;
                SET:     q <= 1'b1;
                TGL:     q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank.sv
// rtl/jk_bank.sv - WIDTH JK cells as flag register, up/down counter or load register; counting under JK_BANK_COUNTER_EN
import jk_bank_pkg::*;

module jk_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic     clk,
    input  logic     rst,
    jk_bank_if.slave bus
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_tc;

`ifdef JK_BANK_COUNTER_EN
    logic [WIDTH-1:0] w_up_t;
    logic [WIDTH-1:0] w_dn_t;

    // Prefix chains: bit i toggles when all lower bits are ones (up) or zeros (down).
    always_comb begin
        w_up_t    = '0;
        w_dn_t    = '0;
        w_up_t[0] = 1'b1;
        w_dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_up_t[i] = w_up_t[i-1] & w_q[i-1];
            w_dn_t[i] = w_dn_t[i-1] & ~w_q[i-1];
        end
    end

    assign w_tc = ~rst & bus.en & (((bus.mode == UP) & (&w_q)) |
                                   ((bus.mode == DOWN) & ~(|w_q)));
`else
    assign w_tc = 1'b0;
`endif

    // en=0 and the non-counting build map onto J=K=0, i.e. hold in every cell.
    always_comb begin
        w_j = '0;
        w_k = '0;
        if (bus.en) begin
            case (bus.mode)
                JK: begin
                    w_j = bus.j;
                    w_k = bus.k;
                end
`ifdef JK_BANK_COUNTER_EN
                UP: begin
                    w_j = w_up_t;
                    w_k = w_up_t;
                end
                DOWN: begin
                    w_j = w_dn_t;
                    w_k = w_dn_t;
                end
`endif
                LOAD: begin
                    w_j = bus.d;
                    w_k = ~bus.d;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RESET_VAL[i]),
            .j       (w_j[i]),
            .k       (w_k[i]),
            .q       (w_q[i])
        );
    end

    assign bus.q    = w_q;
    assign bus.qbar = ~w_q;
    assign bus.tc   = w_tc;

endmodule

// File: tb/tb_jk_bank.sv
// tb/tb_jk_bank.sv - scoreboard bench for jk_bank (expectations follow JK_BANK_COUNTER_EN)
import jk_bank_pkg::*;

module tb_jk_bank;

`ifdef JK_BANK_COUNTER_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    typedef struct {
        logic [7:0] q;
        logic       tc;
        int         id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_id  = 0;
    exp_t sb[$];

    jk_bank_if #(.WIDTH(8)) bus ();

    jk_bank #(
        .WIDTH     (8),
        .RESET_VAL (8'h5A)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL step%0d %s: got %h expected %h", id, name, got, want);
    endtask

    task automatic step(input logic r, input logic e, input mode_e m,
                        input logic [7:0] jj, input logic [7:0] kk, input logic [7:0] dd,
                        input logic [7:0] eq, input logic etc);
        @(negedge clk);
        rst      = r;
        bus.en   = e;
        bus.mode = m;
        bus.j    = jj;
        bus.k    = kk;
        bus.d    = dd;
        sb.push_back('{q: eq, tc: etc, id: step_id});
        step_id++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("q",    e.id, bus.q,    e.q);
                check("qbar", e.id, bus.qbar, ~e.q);
                check("tc",   e.id, {7'd0, bus.tc}, {7'd0, e.tc});
            end
        end
    end

    initial begin : stim
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.mode = JK;
        bus.j    = '0;
        bus.k    = '0;
        bus.d    = '0;

        step(1, 1, UP,   8'h00, 8'h00, 8'h00, 8'h5A, 1'b0);
        step(0, 1, LOAD, 8'h00, 8'h00, 8'hAA, 8'hAA, 1'b0);
        step(0, 1, JK,   8'hF0, 8'h3C, 8'h55, 8'hD2, 1'b0);
        step(0, 1, JK,   8'h00, 8'h00, 8'hFF, 8'hD2, 1'b0);
        step(0, 1, JK,   8'hFF, 8'hFF, 8'h00, 8'h2D, 1'b0);
        step(0, 1, LOAD, 8'h00, 8'h00, 8'hFE, 8'hFE, 1'b0);
        step(0, 1, UP,   8'hFF, 8'h00, 8'h00, CNT ? 8'hFF : 8'hFE, CNT);
        step(0, 1, UP,   8'h00, 8'hFF, 8'h00, CNT ? 8'h00 : 8'hFE, 1'b0);
        step(0, 1, LOAD, 8'h00, 8'h00, 8'h01, 8'h01, 1'b0);
        step(0, 1, DOWN, 8'h00, 8'h00, 8'hAA, CNT ? 8'h00 : 8'h01, CNT);
        step(0, 1, DOWN, 8'h00, 8'h00, 8'h00, CNT ? 8'hFF : 8'h01, 1'b0);
        step(0, 1, LOAD, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        step(0, 0, DOWN, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        step(1, 1, LOAD, 8'h00, 8'h00, 8'h3C, 8'h5A, 1'b0);
        step(0, 1, LOAD, 8'h00, 8'h00, 8'h3C, 8'h3C, 1'b0);
        step(0, 1, LOAD, 8'h00, 8'h00, 8'h10, 8'h10, 1'b0);
        step(0, 1, UP,   8'h00, 8'h00, 8'h00, CNT ? 8'h11 : 8'h10, 1'b0);
        step(0, 1, UP,   8'h00, 8'h00, 8'h00, CNT ? 8'h12 : 8'h10, 1'b0);
        step(0, 1, UP,   8'h00, 8'h00, 8'h00, CNT ? 8'h13 : 8'h10, 1'b0);
        step(0, 1, UP,   8'h00, 8'h00, 8'h00, CNT ? 8'h14 : 8'h10, 1'b0);
        step(0, 1, DOWN, 8'h00, 8'h00, 8'h00, CNT ? 8'h13 : 8'h10, 1'b0);
        step(0, 1, LOAD, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0);
        step(0, 1, JK,   8'h00, 8'h00, 8'h00, 8'hFF, 1'b0);
        step(1, 1, UP,   8'h00, 8'h00, 8'h00, 8'h5A, 1'b0);
        step(0, 0, LOAD, 8'hFF, 8'h00, 8'h00, 8'h5A, 1'b0);
        step(0, 1, JK,   8'h0F, 8'hF0, 8'h00, 8'h0F, 1'b0);

        for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
